note_source_arbiter: RTL



---
 rtl/note_source_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/note_source_arbiter.sv
// note_source_arbiter: shares the buzzer tone path between live keyboard,
// recorder playback and song player, inserting silence gaps on changes.
// Ports: clk, rst (async, active-high); live/rec/song key, pressed, active;
// out_key_id, out_key_pressed, grant (one-hot live/rec/song), busy,
// preempt_count (saturating live preemptions).
module note_source_arbiter #(
  parameter int KEY_ID_BITS = 4,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_ID_BITS-1:0] live_key_id,
  input  logic                   live_pressed,
  input  logic                   rec_active,
  input  logic [KEY_ID_BITS-1:0] rec_key_id,
  input  logic                   rec_pressed,
  input  logic                   song_active,
  input  logic [KEY_ID_BITS-1:0] song_key_id,
  input  logic                   song_pressed,
  output logic [KEY_ID_BITS-1:0] out_key_id,
  output logic                   out_key_pressed,
  output logic [2:0]             grant,
  output logic                   busy,
  output logic [7:0]             preempt_count
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

  localparam logic [2:0] O_LIVE = 3'b001;
  localparam logic [2:0] O_REC  = 3'b010;
  localparam logic [2:0] O_SONG = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [2:0]             owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [KEY_ID_BITS-1:0] key_d;
  logic                   pr_d;
  logic                   pc_inc;

  logic [2:0]             req;
  logic [2:0]             win;

  function automatic logic [KEY_ID_BITS-1:0] sel_key(input logic [2:0] o);
    logic [KEY_ID_BITS-1:0] k;
    k = '0;
    if (o[0])      k = live_key_id;
    else if (o[1]) k = rec_key_id;
    else if (o[2]) k = song_key_id;
    return k;
  endfunction

  function automatic logic sel_pr(input logic [2:0] o);
    logic p;
    p = 1'b0;
    if (o[0])      p = live_pressed;
    else if (o[1]) p = rec_pressed;
    else if (o[2]) p = song_pressed;
    return p;
  endfunction

  always_comb begin
    req = {song_active, rec_active,
           live_pressed && (live_key_id != '0)};
    win = 3'b000;
    if (req[0])      win = O_LIVE;
    else if (req[1]) win = O_REC;
    else if (req[2]) win = O_SONG;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    key_d   = out_key_id;
    pr_d    = out_key_pressed;
    pc_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        key_d = '0;
        pr_d  = 1'b0;
        if (|req) begin
          state_d = S_GRANT;
          owner_d = win;
          key_d   = sel_key(win);
          pr_d    = sel_pr(win);
        end
      end
      S_GRANT: begin
        key_d = sel_key(owner_q);
        pr_d  = sel_pr(owner_q);
        if (!(|(req & owner_q))) begin
          if (|req) begin
            state_d = S_GAP;
            owner_d = win;
            cnt_d   = '0;
            key_d   = out_key_id;
            pr_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            owner_d = 3'b000;
            key_d   = '0;
            pr_d    = 1'b0;
          end
        end else if (owner_q != O_LIVE && req[0]) begin
          state_d = S_GAP;
          owner_d = O_LIVE;
          cnt_d   = '0;
          key_d   = out_key_id;
          pr_d    = 1'b0;
          pc_inc  = 1'b1;
        end else if (sel_pr(owner_q) && out_key_pressed &&
                     sel_key(owner_q) != out_key_id) begin
          // New note from the same owner: articulate with a gap
          state_d = S_GAP;
          cnt_d   = '0;
          key_d   = out_key_id;
          pr_d    = 1'b0;
        end
      end
      S_GAP: begin
        pr_d = 1'b0;
        // Live can steal a pending player slot without restarting the gap
        if (owner_q != O_LIVE && req[0]) begin
          owner_d = O_LIVE;
          pc_inc  = 1'b1;
        end
        if (cnt_q == LAST) begin
          if (|(req & owner_d)) begin
            state_d = S_GRANT;
            key_d   = sel_key(owner_d);
            pr_d    = sel_pr(owner_d);
          end else begin
            state_d = S_IDLE;
            owner_d = 3'b000;
            key_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = 3'b000;
        key_d   = '0;
        pr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      owner_q         <= 3'b000;
      cnt_q           <= '0;
      out_key_id      <= '0;
      out_key_pressed <= 1'b0;
      grant           <= 3'b000;
      busy            <= 1'b0;
      preempt_count   <= 8'd0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      out_key_id      <= key_d;
      out_key_pressed <= pr_d;
      grant           <= (state_d == S_IDLE) ? 3'b000 : owner_d;
      busy            <= (state_d != S_IDLE);
      if (pc_inc && preempt_count != 8'hFF)
        preempt_count <= preempt_count + 8'd1;
    end
  end

endmodule
